// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the core that sits in front of it.
package mem_arbiter_pkg;

  // Core pipeline state, kept here so core and arbiter share one definitions file.
  typedef enum logic [1:0] {
    CoreReset,
    CoreFetch,
    CoreExec,
    CoreHalt
  } state_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_BUSY = 2'd1;
  localparam arb_state_t ARB_RESP = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // A disabled timeout still needs a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout) + 1 : 1;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating busy-cycle counter; expired_o flags a memory access that has waited too long.
module mem_timeout_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (count_q == CntLimit);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [StrbW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic              if_ack_q, if_ack_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic pick;
  logic expired;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (if_req && d_req) begin
      pick = (last_grant_q == REQ_IF) ? REQ_D : REQ_IF;
    end else if (d_req) begin
      pick = REQ_D;
    end else begin
      pick = REQ_IF;
    end
  end

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (state_q == ARB_IDLE),
    .en_i      (state_q == ARB_BUSY),
    .expired_o (expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          state_d      = ARB_BUSY;
          last_grant_d = pick;
          mem_req_d    = 1'b1;
          if (pick == REQ_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_wstrb;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        // A completion in the same cycle as expiry wins over the abort.
        if (mem_ready || expired) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          if (last_grant_q == REQ_D) begin
            d_ack_d   = 1'b1;
            d_err_d   = !mem_ready;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = !mem_ready;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so abort paths are reachable quickly.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wstrb   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_acks", {if_ack, d_ack, if_err, d_err}, 4'b0000);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    tick();
    reset_n = 1'b1;

    // Single fetch with zero-wait memory.
    if_req    = 1'b1;
    if_addr   = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    tick();
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_we", mem_we, 1'b0);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_wstrb", mem_wstrb, 4'h0);
    check("t1_early_ack", if_ack, 1'b0);
    mem_ready = 1'b1;
    tick();
    check("t1_if_ack", if_ack, 1'b1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_if_err", if_err, 1'b0);
    check("t1_d_ack", d_ack, 1'b0);
    check("t1_mem_req_drop", mem_req, 1'b0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("t1_ack_pulse", if_ack, 1'b0);
    check("t1_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Store with three memory wait cycles.
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h40;
    d_wdata   = 32'h12345678;
    d_wstrb   = 4'b0011;
    mem_rdata = 32'hCAFEF00D;
    tick();
    check("t2_mem_req", mem_req, 1'b1);
    check("t2_mem_we", mem_we, 1'b1);
    check("t2_mem_addr", mem_addr, 32'h40);
    check("t2_mem_wdata", mem_wdata, 32'h12345678);
    check("t2_mem_wstrb", mem_wstrb, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_wait_req", mem_req, 1'b1);
      check("t2_wait_ack", d_ack, 1'b0);
    end
    mem_ready = 1'b1;
    tick();
    check("t2_d_ack", d_ack, 1'b1);
    check("t2_d_err", d_err, 1'b0);
    check("t2_d_rdata", d_rdata, 32'hCAFEF00D);
    check("t2_if_ack", if_ack, 1'b0);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    tick();

    // Tie out of reset: expect D, IF, D, IF.
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h100;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h200;
    d_wstrb   = 4'h0;
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_grant_addr", mem_addr, (i % 2 == 0) ? 32'h200 : 32'h100);
      tick();
      check("t3_d_ack", d_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      check("t3_if_ack", if_ack, (i % 2 == 0) ? 1'b0 : 1'b1);
      if (i == 3) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      tick();
    end

    // Timeout abort: ack with err five cycles after mem_req rises.
    mem_ready = 1'b0;
    d_req     = 1'b1;
    d_addr    = 32'h80;
    tick();
    check("t4_mem_req", mem_req, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t4_wait_ack", d_ack, 1'b0);
      check("t4_wait_req", mem_req, 1'b1);
    end
    tick();
    check("t4_d_ack", d_ack, 1'b1);
    check("t4_d_err", d_err, 1'b1);
    check("t4_d_rdata", d_rdata, 32'h0);
    check("t4_mem_req", mem_req, 1'b0);
    d_req = 1'b0;
    tick();
    check("t4_ack_pulse", {d_ack, d_err}, 2'b00);

    // mem_ready in the expiry cycle counts as success.
    d_req     = 1'b1;
    mem_rdata = 32'h600DD00D;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
    end
    mem_ready = 1'b1;
    tick();
    check("t5_d_ack", d_ack, 1'b1);
    check("t5_d_err", d_err, 1'b0);
    check("t5_d_rdata", d_rdata, 32'h600DD00D);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    tick();

    // Asynchronous reset while busy.
    if_req  = 1'b1;
    if_addr = 32'h20;
    tick();
    check("t6_busy_req", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_drop", mem_req, 1'b0);
    check("t6_no_ack", if_ack, 1'b0);
    if_req = 1'b0;
    tick();
    check("t6_addr_clr", mem_addr, 32'h0);
    reset_n = 1'b1;
    tick();
    check("t6_post_idle", {mem_req, if_ack, d_ack}, 3'b000);
    if_req    = 1'b1;
    if_addr   = 32'h30;
    mem_rdata = 32'h0BADF00D;
    tick();
    check("t6_new_addr", mem_addr, 32'h30);
    check("t6_new_req", mem_req, 1'b1);
    mem_ready = 1'b1;
    tick();
    check("t6_if_ack", if_ack, 1'b1);
    check("t6_if_rdata", if_rdata, 32'h0BADF00D);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
